// File: rtl/pa_ahbl_mif_mch.sv
`default_nettype none
// ============================================================================
// Module      : pa_ahbl_mif_mch
// Description : Multi-channel AHB-Lite master interface. Arbitrates NCH
//               requester channels onto one AHB-Lite master port, keeps one
//               registered address phase and one outstanding data phase, and
//               runs a two-cycle ERROR sequence with address-phase retry.
// Revision    : 1.0 - initial release
// ============================================================================
module pa_ahbl_mif_mch #(
  parameter int NCH    = 2,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int ARB_RR = 0
) (
  input  logic            forever_cpuclk,
  input  logic            cpurst,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH-1:0]    ch_write,
  input  logic [NCH*3-1:0]  ch_size,
  input  logic [NCH*4-1:0]  ch_prot,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_grnt,
  output logic [NCH-1:0]    ch_cmplt,
  output logic [NCH-1:0]    ch_err,
  output logic [DW-1:0]     ch_rdata,
  input  logic            halt_req,
  output logic            mif_idle,
  output logic [AW-1:0]   pad_haddr,
  output logic            pad_hwrite,
  output logic [2:0]      pad_hsize,
  output logic [3:0]      pad_hprot,
  output logic [1:0]      pad_htrans,
  output logic [2:0]      pad_hburst,
  output logic [DW-1:0]   pad_hwdata,
  input  logic [DW-1:0]   pad_hrdata,
  input  logic            pad_hready,
  input  logic            pad_hresp,
  output logic [7:0]      mif_dbginfo
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;

  localparam logic [1:0] c_st_norm = 2'd0;
  localparam logic [1:0] c_st_err1 = 2'd1;
  localparam logic [1:0] c_st_err2 = 2'd2;

  logic [1:0]     r_err_st;
  logic [1:0]     w_err_nxt;
  logic           w_norm;
  logic           w_in_err1;

  logic           r_aph_vld;
  logic [CHW-1:0] r_aph_ch;
  logic           r_dph_vld;
  logic [CHW-1:0] r_dph_ch;

  logic [CHW-1:0] w_win;
  logic [CHW-1:0] w_win_lo;
  logic           w_advance;
  logic           w_slot_free;
  logic           w_grant;
  logic           w_cmplt;

  logic [AW-1:0]  w_sel_addr;
  logic           w_sel_write;
  logic [2:0]     w_sel_size;
  logic [3:0]     w_sel_prot;
  logic [DW-1:0]  w_aph_wdata;

  // Error-sequence state register
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) r_err_st <= c_st_norm;
    else        r_err_st <= w_err_nxt;
  end

  // Error-sequence next state: first ERROR cycle has hready low
  always_comb begin
    w_err_nxt = r_err_st;
    case (r_err_st)
      c_st_norm: if (r_dph_vld && pad_hresp && !pad_hready) w_err_nxt = c_st_err1;
      c_st_err1: if (pad_hready) w_err_nxt = c_st_err2;
      c_st_err2: w_err_nxt = c_st_norm;
      default:   w_err_nxt = c_st_norm;
    endcase
  end

  // Error-sequence outputs: ERR1 cancels the pending address phase on the bus
  always_comb begin
    w_norm     = (r_err_st == c_st_norm);
    w_in_err1  = (r_err_st == c_st_err1);
    pad_htrans = (r_aph_vld && !w_in_err1) ? c_htrans_nonseq : c_htrans_idle;
  end

  assign w_advance   = r_aph_vld && pad_hready && w_norm;
  assign w_slot_free = !r_aph_vld || w_advance;
  assign w_grant     = w_slot_free && !halt_req && w_norm && (|ch_req) && !cpurst;
  assign w_cmplt     = r_dph_vld && pad_hready;

  // Lowest-index requester (fixed priority, and round-robin wrap fallback)
  always_comb begin
    w_win_lo = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_req[i]) w_win_lo = CHW'(i);
    end
  end

  generate
    if (ARB_RR != 0) begin : g_rr
      localparam logic [CHW-1:0] c_last_ch = CHW'(NCH - 1);
      logic [CHW-1:0] r_rr_ptr;
      logic [CHW-1:0] w_win_hi;
      logic           w_hi_any;

      // First requester at or after the round-robin pointer
      always_comb begin
        w_win_hi = '0;
        w_hi_any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
          if (ch_req[i] && (CHW'(i) >= r_rr_ptr)) begin
            w_win_hi = CHW'(i);
            w_hi_any = 1'b1;
          end
        end
      end

      assign w_win = w_hi_any ? w_win_hi : w_win_lo;

      // Pointer moves just past the channel that was granted
      always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst)       r_rr_ptr <= '0;
        else if (w_grant) r_rr_ptr <= (w_win == c_last_ch) ? '0 : w_win + 1'b1;
      end
    end else begin : g_fp
      assign w_win = w_win_lo;
    end
  endgenerate

  // Channel muxes for the winner's controls and the address-phase owner's data
  always_comb begin
    w_sel_addr  = '0;
    w_sel_write = 1'b0;
    w_sel_size  = '0;
    w_sel_prot  = '0;
    w_aph_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_win == CHW'(i)) begin
        w_sel_addr  = ch_addr[i*AW +: AW];
        w_sel_write = ch_write[i];
        w_sel_size  = ch_size[i*3 +: 3];
        w_sel_prot  = ch_prot[i*4 +: 4];
      end
      if (r_aph_ch == CHW'(i)) w_aph_wdata = ch_wdata[i*DW +: DW];
    end
  end

  // Address phase: capture on grant, retire on advance; retained across ERROR
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_aph_vld  <= 1'b0;
      r_aph_ch   <= '0;
      pad_haddr  <= '0;
      pad_hwrite <= 1'b0;
      pad_hsize  <= '0;
      pad_hprot  <= '0;
    end else if (w_grant) begin
      r_aph_vld  <= 1'b1;
      r_aph_ch   <= w_win;
      pad_haddr  <= w_sel_addr;
      pad_hwrite <= w_sel_write;
      pad_hsize  <= w_sel_size;
      pad_hprot  <= w_sel_prot;
    end else if (w_advance) begin
      r_aph_vld  <= 1'b0;
    end
  end

  // Data phase: loaded from the address phase, released on completion
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_dph_vld   <= 1'b0;
      r_dph_ch    <= '0;
      pad_hwdata  <= '0;
    end else if (w_advance) begin
      r_dph_vld   <= 1'b1;
      r_dph_ch    <= r_aph_ch;
      pad_hwdata  <= w_aph_wdata;
    end else if (w_cmplt) begin
      r_dph_vld   <= 1'b0;
    end
  end

  // Per-channel one-hot strobes
  always_comb begin
    ch_grnt  = '0;
    ch_cmplt = '0;
    ch_err   = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_grnt[i]  = w_grant && (w_win == CHW'(i));
      ch_cmplt[i] = w_cmplt && (r_dph_ch == CHW'(i));
      ch_err[i]   = w_cmplt && (r_dph_ch == CHW'(i)) && (pad_hresp || w_in_err1);
    end
  end

  assign ch_rdata    = pad_hrdata;
  assign pad_hburst  = 3'b000;
  assign mif_idle    = !r_aph_vld && !r_dph_vld && w_norm;
  assign mif_dbginfo = {r_aph_vld, r_dph_vld, r_err_st, 4'(r_dph_ch)};

endmodule
`default_nettype wire

// File: tb/tb_pa_ahbl_mif_mch.sv
`default_nettype none
// ============================================================================
// Module      : tb_pa_ahbl_mif_mch
// Description : Directed self-checking bench for pa_ahbl_mif_mch (NCH=4),
//               round-robin instance plus a fixed-priority instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pa_ahbl_mif_mch;

  localparam int NCH = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_req;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH-1:0]    ch_write;
  logic [NCH*3-1:0]  ch_size;
  logic [NCH*4-1:0]  ch_prot;
  logic [NCH*DW-1:0] ch_wdata;
  logic              halt_req;
  logic [DW-1:0]     hrdata;
  logic              hready;
  logic              hresp;

  logic [NCH-1:0] grnt, cmplt, err;
  logic [DW-1:0]  rdata;
  logic           idle;
  logic [AW-1:0]  haddr;
  logic           hwrite;
  logic [2:0]     hsize, hburst;
  logic [3:0]     hprot;
  logic [1:0]     htrans;
  logic [DW-1:0]  hwdata;
  logic [7:0]     dbg;

  logic [NCH-1:0] fp_grnt, fp_cmplt, fp_err;
  logic [DW-1:0]  fp_rdata;
  logic           fp_idle;
  logic [AW-1:0]  fp_haddr;
  logic           fp_hwrite;
  logic [2:0]     fp_hsize, fp_hburst;
  logic [3:0]     fp_hprot;
  logic [1:0]     fp_htrans;
  logic [DW-1:0]  fp_hwdata;
  logic [7:0]     fp_dbg;

  int n_cmp;
  int n_bad;
  int rr_seq [5] = '{0, 1, 2, 3, 0};

  pa_ahbl_mif_mch #(.NCH(NCH), .AW(AW), .DW(DW), .ARB_RR(1)) dut (
    .forever_cpuclk(clk), .cpurst(rst),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_write(ch_write), .ch_size(ch_size),
    .ch_prot(ch_prot), .ch_wdata(ch_wdata),
    .ch_grnt(grnt), .ch_cmplt(cmplt), .ch_err(err), .ch_rdata(rdata),
    .halt_req(halt_req), .mif_idle(idle),
    .pad_haddr(haddr), .pad_hwrite(hwrite), .pad_hsize(hsize), .pad_hprot(hprot),
    .pad_htrans(htrans), .pad_hburst(hburst), .pad_hwdata(hwdata),
    .pad_hrdata(hrdata), .pad_hready(hready), .pad_hresp(hresp),
    .mif_dbginfo(dbg)
  );

  pa_ahbl_mif_mch #(.NCH(NCH), .AW(AW), .DW(DW), .ARB_RR(0)) dut_fp (
    .forever_cpuclk(clk), .cpurst(rst),
    .ch_req(ch_req), .ch_addr(ch_addr), .ch_write(ch_write), .ch_size(ch_size),
    .ch_prot(ch_prot), .ch_wdata(ch_wdata),
    .ch_grnt(fp_grnt), .ch_cmplt(fp_cmplt), .ch_err(fp_err), .ch_rdata(fp_rdata),
    .halt_req(halt_req), .mif_idle(fp_idle),
    .pad_haddr(fp_haddr), .pad_hwrite(fp_hwrite), .pad_hsize(fp_hsize), .pad_hprot(fp_hprot),
    .pad_htrans(fp_htrans), .pad_hburst(fp_hburst), .pad_hwdata(fp_hwdata),
    .pad_hrdata(hrdata), .pad_hready(hready), .pad_hresp(hresp),
    .mif_dbginfo(fp_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; checks run on the falling edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    ch_req = '0;
    rst    = 1'b1;
    step();
    rst    = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; ch_req = '0; ch_addr = '0; ch_write = '0; ch_size = '0;
    ch_prot = '0; ch_wdata = '0; halt_req = 1'b0; hrdata = '0; hready = 1'b1; hresp = 1'b0;

    // ---------------- reset state
    step(); step();
    samp();
    chk("rst_htrans", htrans, 2'b00);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_grnt", grnt, 4'b0);
    chk("rst_cmplt", cmplt, 4'b0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_dbg", dbg, 8'h00);
    chk("rst_hburst", hburst, 3'b000);
    step(); rst = 1'b0;

    // ---------------- T1 single read on ch1
    step();
    ch_req = 4'b0010; ch_addr[1*AW +: AW] = 32'h2000_0010; ch_size[1*3 +: 3] = 3'd2;
    ch_prot[1*4 +: 4] = 4'h3; ch_write[1] = 1'b0;
    samp();
    chk("t1_grnt", grnt, 4'b0010);
    chk("t1_htrans_c0", htrans, 2'b00);
    step(); ch_req = '0;
    samp();
    chk("t1_htrans_c1", htrans, 2'b10);
    chk("t1_haddr", haddr, 32'h2000_0010);
    chk("t1_hsize", hsize, 3'd2);
    chk("t1_hprot", hprot, 4'h3);
    chk("t1_hwrite", hwrite, 1'b0);
    chk("t1_busy", idle, 1'b0);
    step(); hrdata = 32'hA5A5_0001;
    samp();
    chk("t1_cmplt", cmplt, 4'b0010);
    chk("t1_rdata", rdata, 32'hA5A5_0001);
    chk("t1_err", err, 4'b0);
    chk("t1_htrans_c2", htrans, 2'b00);
    step();
    samp();
    chk("t1_idle", idle, 1'b1);

    // ---------------- T2 round-robin vs fixed priority, all requesting
    do_reset();
    for (int k = 0; k < 7; k++) begin
      step();
      ch_req = (k < 5) ? 4'hF : 4'h0;
      samp();
      if (k < 5) begin
        chk("t2_rr_grnt", grnt, 64'(1 << rr_seq[k]));
        chk("t2_fp_grnt", fp_grnt, 4'b0001);
      end else begin
        chk("t2_rr_nogrnt", grnt, 4'b0);
      end
      if (k >= 2) chk("t2_rr_cmplt", cmplt, 64'(1 << rr_seq[k-2]));
    end

    // ---------------- T3 back-to-back writes, 2 wait states each
    do_reset();
    step();
    ch_req = 4'b0001; ch_addr[0 +: AW] = 32'h10; ch_write[0] = 1'b1; ch_wdata[0 +: DW] = 32'h11;
    samp(); chk("t3_grnt1", grnt, 4'b0001);
    step(); ch_addr[0 +: AW] = 32'h14;
    samp(); chk("t3_grnt2", grnt, 4'b0001); chk("t3_haddr1", haddr, 32'h10);
    step(); ch_req = '0; ch_wdata[0 +: DW] = 32'h22; hready = 1'b0;
    samp(); chk("t3_haddr2", haddr, 32'h14); chk("t3_htrans2", htrans, 2'b10);
    chk("t3_hwdata1_w1", hwdata, 32'h11);
    step();
    samp(); chk("t3_hwdata1_w2", hwdata, 32'h11); chk("t3_nocmplt", cmplt, 4'b0);
    step(); hready = 1'b1;
    samp(); chk("t3_cmplt1", cmplt, 4'b0001); chk("t3_hwdata1_end", hwdata, 32'h11);
    step(); hready = 1'b0;
    samp(); chk("t3_hwdata2", hwdata, 32'h22); chk("t3_htrans_idle", htrans, 2'b00);
    chk("t3_dbg", dbg, 8'h40); chk("t3_nocmplt2", cmplt, 4'b0);
    step();
    samp();
    step(); hready = 1'b1;
    samp(); chk("t3_cmplt2", cmplt, 4'b0001);
    step(); ch_write[0] = 1'b0;
    samp(); chk("t3_idle", idle, 1'b1);

    // ---------------- T4 ERROR with ch1 address phase pending
    do_reset();
    step(); ch_req = 4'b0001; ch_addr[0 +: AW] = 32'h100;
    samp(); chk("t4_grnt0", grnt, 4'b0001);
    step(); ch_req = 4'b0010; ch_addr[1*AW +: AW] = 32'h200;
    samp(); chk("t4_grnt1", grnt, 4'b0010);
    step(); ch_req = '0; hresp = 1'b1; hready = 1'b0;
    samp(); chk("t4_htrans_e0", htrans, 2'b10); chk("t4_haddr_e0", haddr, 32'h200);
    chk("t4_nocmplt", cmplt, 4'b0);
    step(); hready = 1'b1;
    samp(); chk("t4_htrans_err1", htrans, 2'b00); chk("t4_cmplt_err", cmplt, 4'b0001);
    chk("t4_err", err, 4'b0001); chk("t4_dbg_err1", dbg, 8'hD0); chk("t4_nogrnt", grnt, 4'b0);
    step(); hresp = 1'b0;
    samp(); chk("t4_htrans_err2", htrans, 2'b10); chk("t4_haddr_retry", haddr, 32'h200);
    chk("t4_cmplt_none", cmplt, 4'b0); chk("t4_dbg_err2", dbg, 8'hA0);
    step();
    samp(); chk("t4_htrans_norm", htrans, 2'b10); chk("t4_dbg_norm", dbg, 8'h80);
    step(); hrdata = 32'h1234;
    samp(); chk("t4_cmplt1", cmplt, 4'b0010); chk("t4_err1", err, 4'b0);
    chk("t4_rdata", rdata, 32'h1234);
    step();
    samp(); chk("t4_idle", idle, 1'b1);

    // ---------------- T5 halt during a 3-wait-state data phase
    do_reset();
    step(); ch_req = 4'b0100; ch_addr[2*AW +: AW] = 32'h300;
    samp(); chk("t5_grnt2", grnt, 4'b0100);
    step(); ch_req = '0;
    samp(); chk("t5_htrans", htrans, 2'b10);
    step(); halt_req = 1'b1; ch_req = 4'b1000; ch_addr[3*AW +: AW] = 32'h400; hready = 1'b0;
    samp(); chk("t5_nogrnt_w1", grnt, 4'b0); chk("t5_nocmplt", cmplt, 4'b0);
    step();
    samp(); chk("t5_nogrnt_w2", grnt, 4'b0);
    step();
    samp(); chk("t5_nogrnt_w3", grnt, 4'b0); chk("t5_busy", idle, 1'b0);
    step(); hready = 1'b1;
    samp(); chk("t5_cmplt", cmplt, 4'b0100); chk("t5_busy_cmplt", idle, 1'b0);
    step();
    samp(); chk("t5_idle", idle, 1'b1); chk("t5_nogrnt_idle", grnt, 4'b0);
    step(); halt_req = 1'b0;
    samp(); chk("t5_grnt3", grnt, 4'b1000);
    step(); ch_req = '0;
    samp(); chk("t5_haddr3", haddr, 32'h400);
    step();
    samp(); chk("t5_cmplt3", cmplt, 4'b1000);

    // ---------------- T6 reset asserted in a wait state
    step(); ch_req = 4'b0010; ch_addr[1*AW +: AW] = 32'h500; ch_write[1] = 1'b1;
    ch_wdata[1*DW +: DW] = 32'h55;
    samp(); chk("t6_grnt", grnt, 4'b0010);
    step(); ch_req = '0;
    samp(); chk("t6_htrans", htrans, 2'b10);
    step(); hready = 1'b0;
    samp(); chk("t6_hwdata", hwdata, 32'h55); chk("t6_dbg_dph", dbg, 8'h41);
    #2; rst = 1'b1; ch_req = 4'b0010;
    #1;
    chk("t6_rst_htrans", htrans, 2'b00); chk("t6_rst_haddr", haddr, 32'h0);
    chk("t6_rst_hwdata", hwdata, 32'h0); chk("t6_rst_grnt", grnt, 4'b0);
    chk("t6_rst_cmplt", cmplt, 4'b0); chk("t6_rst_idle", idle, 1'b1);
    chk("t6_rst_dbg", dbg, 8'h00);
    step(); rst = 1'b0; hready = 1'b1;
    samp(); chk("t6_regrnt", grnt, 4'b0010);
    step(); ch_req = '0;
    samp(); chk("t6_haddr", haddr, 32'h500);
    step();
    samp(); chk("t6_cmplt", cmplt, 4'b0010);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
